// File: rtl/core_pkg.sv
// Shared fetch-path definitions: fetch FSM states, address width, reset PC and PC step.
package core_pkg;

    localparam int          ADDR_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INCR          = 32'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_incr.sv
// Sequential-address adder: pc + 4, wrapping mod 2^W. Shared with branch-target logic.
module pc_incr
    import core_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] pc,
    output logic [W-1:0] pc_plus4
);

    assign pc_plus4 = pc + PC_INCR[W-1:0];

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Architectural PC register and instruction-fetch sequencer (IDLE/FETCH/EXEC/HALTED).
// Optional misaligned-target trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = core_pkg::RESET_PC_DEFAULT,
    parameter int          ADDR_W   = core_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] next_addr,
    input  logic              exec_done,
    input  logic              halt_req,
    input  logic              resume,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              halted,
    output logic [31:0]       fetch_count,
    output logic              trap
);
    import core_pkg::*;

    // Handshake: imem_req is high with imem_addr stable for the whole FETCH state;
    // the transfer happens on the first rising edge where imem_ready is also high.

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] pc_next;
    logic [31:0]       instr_next;
    logic              instr_valid_next;
    logic [31:0]       fetch_count_next;

`ifdef PC_MISALIGN_TRAP_EN
    logic trap_q, trap_next;
`else
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
`endif

    pc_incr #(.W(ADDR_W)) u_pc_incr (
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    always_comb begin
        state_next       = state;
        pc_next          = pc;
        instr_next       = instr;
        instr_valid_next = instr_valid;
        fetch_count_next = fetch_count;
`ifdef PC_MISALIGN_TRAP_EN
        trap_next        = trap_q;
`endif
        unique case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                if (imem_ready) begin
                    instr_next       = imem_rdata;
                    instr_valid_next = 1'b1;
                    fetch_count_next = fetch_count + 32'd1;
                    state_next       = EXEC;
                end
            end
            EXEC: begin
                if (exec_done) begin
                    instr_valid_next = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
                    if (next_addr[1:0] != 2'b00) begin
                        trap_next  = 1'b1;
                        state_next = HALTED;
                    end else begin
                        pc_next    = next_addr;
                        state_next = halt_req ? HALTED : FETCH;
                    end
`else
                    pc_next    = next_addr & ALIGN_MASK;
                    state_next = halt_req ? HALTED : FETCH;
`endif
                end
            end
            HALTED: begin
                if (resume) begin
`ifdef PC_MISALIGN_TRAP_EN
                    trap_next = 1'b0;
`endif
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_count <= '0;
`ifdef PC_MISALIGN_TRAP_EN
            trap_q      <= 1'b0;
`endif
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instr       <= instr_next;
            instr_valid <= instr_valid_next;
            fetch_count <= fetch_count_next;
`ifdef PC_MISALIGN_TRAP_EN
            trap_q      <= trap_next;
`endif
        end
    end

    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;
    assign halted    = (state == HALTED);

`ifdef PC_MISALIGN_TRAP_EN
    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

endmodule
